// File: rtl/dmem_responder.sv
// Memory-side ld/st responder: word data array plus an in-order completion FIFO
// with per-entry latency countdowns. Optional macro DMEM_VARLAT_EN adds EXTRA_LAT to odd word indices.
module dmem_responder #(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024,
    parameter int EXTRA_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        rw_in,
    input  logic [3:0]  id_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic [3:0]  id_out,
    output logic        ready_out,
    output logic        stall_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(LATENCY + EXTRA_LAT + 1);

    logic [31:0]   mem      [MEM_WORDS];
    logic [3:0]    ent_id   [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [CW-1:0] ent_cnt  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [IW-1:0] idx;
    logic          push;
    logic          pop;
    logic [CW-1:0] init_cnt;
    logic [DEPTH-1:0] occ;
    logic          unused_addr;

    assign idx         = addr_in[IW+1:2];
    assign unused_addr = ^{addr_in[31:IW+2], addr_in[1:0]};
    assign stall_out   = (count == (PW+1)'(DEPTH));
    assign push        = valid_in && !stall_out;
    assign pop         = (count != '0) && (ent_cnt[head] == '0);

    always_comb begin
        init_cnt = CW'(LATENCY - 1);
`ifdef DMEM_VARLAT_EN
        if (idx[0]) init_cnt = CW'(LATENCY - 1 + EXTRA_LAT);
`endif
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ({1'b0, PW'(i) - head}) < count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ready_out <= 1'b0;
            id_out    <= '0;
            data_out  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_id[i]   <= '0;
                ent_data[i] <= '0;
                ent_cnt[i]  <= '0;
            end
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i] && ent_cnt[i] != '0) ent_cnt[i] <= ent_cnt[i] - CW'(1);
            end

            // Tail slot is never live when push is allowed, so this write wins cleanly.
            if (push) begin
                ent_id[tail]   <= id_in;
                ent_data[tail] <= rw_in ? data_in : mem[idx];
                ent_cnt[tail]  <= init_cnt;
                tail           <= tail + PW'(1);
                if (rw_in) mem[idx] <= data_in;
            end

            ready_out <= pop;
            if (pop) begin
                id_out   <= ent_id[head];
                data_out <= ent_data[head];
                head     <= head + PW'(1);
            end

            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
        end
    end
endmodule
